// File: rtl/iir_out_fifo_pkg.sv
// rtl/iir_out_fifo_pkg.sv - shared widths and sizing helpers for the iir output fifo
package iir_out_fifo_pkg;

  // Default sample width, matching the iir_filter data path.
  localparam int NB_DEFAULT    = 12;

  // Default number of stored samples; must be a power of two, at least 2.
  localparam int DEPTH_DEFAULT = 8;

  // Width of a read or write pointer for a given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Width of the occupancy count; one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iir_out_fifo_if.sv
// rtl/iir_out_fifo_if.sv - producer/consumer handshake bundle for the iir output fifo
interface iir_out_fifo_if
  import iir_out_fifo_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
);

  localparam int CW = cnt_w(DEPTH);

  // Write side, driven by iir_filter vOut/dOut.
  logic          vIn;
  logic [NB-1:0] dIn;

  // Read side: show-ahead head sample and consumer ready.
  logic          rdy;
  logic          vOut;
  logic [NB-1:0] dOut;

  // Status and sticky overflow control.
  logic [CW-1:0] count;
  logic          ovf;
  logic          clr_ovf;

  // Environment side: feeds samples, consumes the head, clears overflow.
  modport master (
    output vIn, dIn, rdy, clr_ovf,
    input  vOut, dOut, count, ovf
  );

  // FIFO side.
  modport slave (
    input  vIn, dIn, rdy, clr_ovf,
    output vOut, dOut, count, ovf
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x NB register array, one synchronous write port, one asynchronous read port
module fifo_mem
  import iir_out_fifo_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [NB-1:0]           wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [NB-1:0]           rdata
);

  // Storage is deliberately not reset; validity is tracked by the count in the top level.
  logic [NB-1:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read gives the show-ahead head sample with no extra latency.
  assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_fifo.sv
// rtl/iir_out_fifo.sv - show-ahead output fifo with sticky overflow for the iir filter
module iir_out_fifo
  import iir_out_fifo_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  iir_out_fifo_if.slave bus
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          not_empty;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [NB-1:0] mem_rdata;

  // Handshake decode from the registered count only, so inputs never reach vOut/dOut in the same cycle.
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == FULL_COUNT);
    rd_en     = not_empty & bus.rdy;
    // A full fifo still takes a sample when the head is retired at the same edge.
    wr_en     = bus.vIn & (~full | rd_en);
    drop      = bus.vIn & full & ~rd_en;
  end

  // Writes are gated by rst so a sample presented during reset never lands in storage.
  fifo_mem #(
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en & ~rst),
    .waddr (wr_ptr),
    .wdata (bus.dIn),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers, occupancy and sticky overflow; pointers wrap naturally at 2**AW == DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_en) begin
        count_q <= count_q + CW'(1);
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - CW'(1);
      end
      // A drop wins over a simultaneous clear so no overflow event is ever lost.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.vOut  = not_empty;
  assign bus.dOut  = mem_rdata;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
// tb/tb_iir_out_fifo.sv - directed self-checking bench for iir_out_fifo
`timescale 1ns/1ps
module tb_iir_out_fifo;
  import iir_out_fifo_pkg::*;

  localparam int NB    = NB_DEFAULT;
  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int CW    = cnt_w(DEPTH);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iir_out_fifo_if #(.NB(NB), .DEPTH(DEPTH)) bus ();

  iir_out_fifo #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vIn     = 1'b0;
    bus.dIn     = '0;
    bus.rdy     = 1'b0;
    bus.clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rdy = 1'b1;
    do_reset();
    checks++;
    if (bus.count !== CW'(0)) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", bus.count);
    end
    checks++;
    if (bus.vOut !== 1'b0) begin
      failures++; $display("FAIL reset_vout got=%b exp=0", bus.vOut);
    end
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf);
    end
    // rdy with an empty fifo must not read.
    step();
    checks++;
    if (bus.count !== CW'(0)) begin
      failures++; $display("FAIL empty_read_count got=%0d exp=0", bus.count);
    end
  endtask

  task automatic test_passthrough();
    logic [NB-1:0] vals [4];
    vals[0] = 12'd5;
    vals[1] = 12'hFFD;
    vals[2] = 12'h7FF;
    vals[3] = 12'h800;
    idle_inputs();
    bus.rdy = 1'b1;
    bus.vIn = 1'b1;
    bus.dIn = vals[0];
    #1;
    checks++;
    if (bus.vOut !== 1'b0) begin
      failures++; $display("FAIL no_fallthrough got=%b exp=0", bus.vOut);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dIn = vals[i];
      step();
      checks++;
      if (bus.vOut !== 1'b1 || bus.dOut !== vals[i]) begin
        failures++; $display("FAIL pass_data[%0d] got=%b/%h exp=1/%h", i, bus.vOut, bus.dOut, vals[i]);
      end
      checks++;
      if (bus.count !== CW'(1)) begin
        failures++; $display("FAIL pass_count[%0d] got=%0d exp=1", i, bus.count);
      end
    end
    bus.vIn = 1'b0;
    step();
    checks++;
    if (bus.count !== CW'(0) || bus.vOut !== 1'b0) begin
      failures++; $display("FAIL pass_drain got=%0d/%b exp=0/0", bus.count, bus.vOut);
    end
  endtask

  task automatic test_overflow();
    idle_inputs();
    do_reset();
    bus.vIn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.dIn = NB'(i);
      step();
    end
    checks++;
    if (bus.count !== CW'(8) || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL fill8 got=%0d/%b exp=8/0", bus.count, bus.ovf);
    end
    bus.dIn = NB'(9);
    step();
    checks++;
    if (bus.count !== CW'(8) || bus.ovf !== 1'b1) begin
      failures++; $display("FAIL drop9 got=%0d/%b exp=8/1", bus.count, bus.ovf);
    end
    bus.vIn = 1'b0;
    bus.rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.vOut !== 1'b1 || bus.dOut !== NB'(i)) begin
        failures++; $display("FAIL ovf_drain[%0d] got=%b/%0d exp=1/%0d", i, bus.vOut, bus.dOut, i);
      end
      step();
    end
    checks++;
    if (bus.vOut !== 1'b0 || bus.count !== CW'(0)) begin
      failures++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", bus.vOut, bus.count);
    end
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf);
    end
  endtask

  task automatic test_full_rw();
    logic [NB-1:0] exp_seq [8];
    idle_inputs();
    do_reset();
    bus.vIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dIn = NB'(11 + i);
      step();
    end
    bus.dIn = NB'(100);
    bus.rdy = 1'b1;
    step();
    bus.vIn = 1'b0;
    checks++;
    if (bus.count !== CW'(8) || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL full_rw got=%0d/%b exp=8/0", bus.count, bus.ovf);
    end
    for (int i = 0; i < 7; i++) exp_seq[i] = NB'(12 + i);
    exp_seq[7] = NB'(100);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.vOut !== 1'b1 || bus.dOut !== exp_seq[i]) begin
        failures++; $display("FAIL full_rw_out[%0d] got=%b/%0d exp=1/%0d", i, bus.vOut, bus.dOut, exp_seq[i]);
      end
      step();
    end
    checks++;
    if (bus.count !== CW'(0)) begin
      failures++; $display("FAIL full_rw_empty got=%0d exp=0", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    int            q [$];
    int            sent;
    int            cyc;
    bit            rd;
    bit            held_valid;
    logic [NB-1:0] held;
    idle_inputs();
    do_reset();
    sent       = 0;
    cyc        = 0;
    held_valid = 0;
    held       = '0;
    while ((sent < 20 || q.size() != 0) && cyc < 200) begin
      bus.rdy = (cyc % 2 == 0);
      rd      = bus.rdy && (q.size() != 0);
      bus.vIn = (sent < 20) && ((q.size() < DEPTH) || rd);
      bus.dIn = NB'(200 + sent);
      #1;
      checks++;
      if (bus.count !== CW'(q.size()) || bus.vOut !== (q.size() != 0)) begin
        failures++; $display("FAIL stream_count[%0d] got=%0d/%b exp=%0d", cyc, bus.count, bus.vOut, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (bus.dOut !== NB'(q[0])) begin
          failures++; $display("FAIL stream_data[%0d] got=%0d exp=%0d", cyc, bus.dOut, q[0]);
        end
      end
      if (held_valid) begin
        checks++;
        if (bus.dOut !== held) begin
          failures++; $display("FAIL stream_hold[%0d] got=%0d exp=%0d", cyc, bus.dOut, held);
        end
      end
      held_valid = (bus.rdy == 1'b0) && (q.size() != 0);
      held       = bus.dOut;
      step();
      if (rd) void'(q.pop_front());
      if (bus.vIn) begin
        q.push_back(200 + sent);
        sent++;
      end
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      failures++; $display("FAIL stream_timeout got=%0d exp<200", cyc);
    end
    idle_inputs();
    checks++;
    if (bus.count !== CW'(0) || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL stream_end got=%0d/%b exp=0/0", bus.count, bus.ovf);
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    do_reset();
    bus.vIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dIn = NB'(31 + i);
      step();
    end
    checks++;
    if (bus.count !== CW'(3)) begin
      failures++; $display("FAIL mid_load got=%0d exp=3", bus.count);
    end
    rst         = 1'b1;
    bus.dIn     = NB'(77);
    bus.rdy     = 1'b1;
    step();
    rst     = 1'b0;
    bus.vIn = 1'b0;
    bus.rdy = 1'b0;
    checks++;
    if (bus.count !== CW'(0) || bus.vOut !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", bus.count, bus.vOut, bus.ovf);
    end
    step();
    checks++;
    if (bus.count !== CW'(0)) begin
      failures++; $display("FAIL mid_reset_discard got=%0d exp=0", bus.count);
    end
    bus.vIn = 1'b1;
    bus.dIn = NB'(55);
    step();
    bus.vIn = 1'b0;
    checks++;
    if (bus.count !== CW'(1) || bus.dOut !== NB'(55)) begin
      failures++; $display("FAIL post_reset_write got=%0d/%0d exp=1/55", bus.count, bus.dOut);
    end
  endtask

  task automatic test_ovf_priority();
    idle_inputs();
    do_reset();
    bus.vIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dIn = NB'(i);
      step();
    end
    bus.dIn     = NB'(99);
    bus.clr_ovf = 1'b1;
    step();
    bus.vIn     = 1'b0;
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.ovf !== 1'b1 || bus.count !== CW'(8)) begin
      failures++; $display("FAIL ovf_set_priority got=%b/%0d exp=1/8", bus.ovf, bus.count);
    end
    step();
    checks++;
    if (bus.ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.ovf);
    end
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear_pulse got=%b exp=0", bus.ovf);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_mid_reset();
    test_ovf_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_out_fifo.md
IIR_OUT_FIFO -- requirements
Module: iir_out_fifo

Interface
REQ-001 The block SHALL have parameter NB, default 12, giving the sample width and matching the iir_filter data width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of stored samples; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port vIn, input, 1 bit: the write strobe, driven by iir_filter vOut.
REQ-006 The block SHALL have port dIn, input, NB bits: the write data, driven by iir_filter dOut, two's complement.
REQ-007 The block SHALL have port rdy, input, 1 bit: the consumer is ready to take the head sample.
REQ-008 The block SHALL have port vOut, output, 1 bit: the head sample on dOut is valid.
REQ-009 The block SHALL have port dOut, output, NB bits: the head sample.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of stored samples, from 0 to DEPTH.
REQ-011 The block SHALL have port ovf, output, 1 bit: a sticky flag showing that a sample was dropped.
REQ-012 The block SHALL have port clr_ovf, input, 1 bit: a synchronous clear for ovf.

Function
REQ-013 A write SHALL be accepted at a clock edge when vIn=1 and either count<DEPTH, or count=DEPTH and a read occurs at the same edge.
REQ-014 A read SHALL occur at a clock edge when vOut=1 and rdy=1; the head entry is then retired.
REQ-015 vOut SHALL equal (count!=0) at all times; dOut SHALL present the entry at the read pointer (show-ahead).
REQ-016 Latency SHALL be exactly one cycle: a sample written at edge k SHALL appear on dOut with vOut=1 in the cycle after edge k, when the FIFO was empty.
REQ-017 There SHALL be no combinational path from dIn or vIn to dOut or vOut; writing while empty SHALL NOT fall through in the same cycle.
REQ-018 When vIn=1, count=DEPTH and no read occurs, the sample SHALL be dropped, the contents SHALL be unchanged, and ovf SHALL be set at that edge.
REQ-019 After a write and a read at the same edge, count SHALL be unchanged; this SHALL also hold when count=DEPTH.
REQ-020 When count=0, a read SHALL NOT occur, whatever the value of rdy.
REQ-021 The read and write pointers SHALL each be log2(DEPTH) bits and SHALL wrap modulo DEPTH; full and empty SHALL be determined from count only.
REQ-022 Sample order SHALL be preserved through pointer wrap-around.
REQ-023 dOut SHALL be stable while vOut=1 and rdy=0.
REQ-024 When clr_ovf=1 and an overflow drop occur at the same edge, ovf SHALL end up 1 (set has priority over clear).
REQ-025 Data SHALL pass through bit-exact: no saturation, rounding or sign change.

Reset
REQ-026 While rst=1 at an edge, count, both pointers and ovf SHALL be cleared to 0, so vOut=0.
REQ-027 rst SHALL have priority over vIn, rdy and clr_ovf; samples presented during reset SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL discard all stored samples; dOut is don't-care while vOut=0.
REQ-029 Storage memory SHALL NOT require reset.

Structure
REQ-030 The default NB and DEPTH, and the count-width function log2(DEPTH)+1, SHALL be placed in the shared filter package, so that iir_filter and the testbench use the same widths.
REQ-031 Storage SHALL be one sub-module, fifo_mem: a DEPTH x NB register array with one synchronous write port and one asynchronous read port.
REQ-032 The top level SHALL hold the pointers, count, ovf and handshake logic.

Verification
REQ-033 Scenario 1: write 5, -3, 2047, -2048 with rdy=1 -> the same four values appear in order, each 1 cycle after its write; count never exceeds 1.
REQ-034 Scenario 2: with rdy=0, write 8 samples (values 1 to 8), then a 9th (value 9) -> count=8, ovf=1; then set rdy=1 -> outputs are 1 to 8 and 9 never appears.
REQ-035 Scenario 3: with count=8, apply vIn=1 with value 100 and rdy=1 at the same edge -> count stays 8, ovf stays 0, and 100 is output last.
REQ-036 Scenario 4: stream 20 samples with rdy toggling 1,0,1,0,... -> pointers wrap, order is preserved, and dOut is held while rdy=0.
REQ-037 Scenario 5: load 3 samples, then assert rst for 1 cycle with vIn=1 -> next cycle count=0, vOut=0, ovf=0, and the sample presented during reset is not stored.
REQ-038 Scenario 6: hold clr_ovf=1 during an overflow drop -> ovf=1; the next clr_ovf pulse with no drop -> ovf=0.
